// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler that time-shares one binary-to-BCD converter among
// NREQ requesters and holds a {tens,ones} result register per requester.
module bcd_conv_scheduler #(
    parameter int NREQ     = 3,
    parameter int CONV_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [6*NREQ-1:0]   bin_in,
    output logic [5:0]          conv_bin,
    input  logic [3:0]          conv_hundred,
    input  logic [3:0]          conv_tens,
    input  logic [3:0]          conv_ones,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     ack,
    output logic [8*NREQ-1:0]   bcd_out,
    output logic                range_err,
    output logic                busy
);

    localparam int PW = (NREQ < 2) ? 1 : $clog2(NREQ);
    localparam int CW = (CONV_LAT < 1) ? 1 : $clog2(CONV_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] sel;
    logic          found;
    logic [CW-1:0] cnt;

    // Round-robin pick: first requester above the last-served one, with wrap.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[PW'((int'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // NOTE: the per-requester result registers are cleared on reset because the
    // display must show zeros after reset, not stale digits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_bin  <= '0;
            grant     <= '0;
            ack       <= '0;
            bcd_out   <= '0;
            range_err <= 1'b0;
            ptr       <= PW'(NREQ - 1);
            cur       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= NREQ'(1) << sel;
                        cur      <= sel;
                        conv_bin <= bin_in[6*int'(sel) +: 6];
                        cnt      <= CW'(CONV_LAT);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bcd_out[8*int'(cur) +: 8] <= {conv_tens, conv_ones};
                        ack       <= NREQ'(1) << cur;
                        // A hundreds digit can only appear if the converter saw >99.
                        range_err <= (conv_bin > 6'd59) || (conv_hundred != 4'd0);
                        grant     <= '0;
                        ptr       <= cur;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    ack       <= '0;
                    range_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: registered converter model, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_bcd_conv_scheduler;

    localparam int NREQ     = 3;
    localparam int CONV_LAT = 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [6*NREQ-1:0]   bin_in;
    logic [5:0]          conv_bin;
    logic [3:0]          conv_hundred;
    logic [3:0]          conv_tens;
    logic [3:0]          conv_ones;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     ack;
    logic [8*NREQ-1:0]   bcd_out;
    logic                range_err;
    logic                busy;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_conv_scheduler #(.NREQ(NREQ), .CONV_LAT(CONV_LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .bin_in       (bin_in),
        .conv_bin     (conv_bin),
        .conv_hundred (conv_hundred),
        .conv_tens    (conv_tens),
        .conv_ones    (conv_ones),
        .grant        (grant),
        .ack          (ack),
        .bcd_out      (bcd_out),
        .range_err    (range_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Registered (one-cycle) binary-to-BCD converter.
    logic [3:0] cv_h = '0;
    logic       hund_force = 1'b0;
    always @(posedge clk) begin
        cv_h      <= 4'(conv_bin / 100);
        conv_tens <= 4'(conv_bin / 10);
        conv_ones <= 4'(conv_bin % 10);
    end
    assign conv_hundred = hund_force ? 4'd1 : cv_h;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction occupies CONV_LAT+3 edges counted from
    // the grant edge; results are plain decimal digits of the snapshot.
    int         m_cyc;
    int         m_k;
    int         m_ptr;
    logic [5:0] m_val;
    logic [7:0] m_bcd [NREQ];
    logic       m_rerr;

    task automatic model_reset();
        m_cyc  = 0;
        m_k    = 0;
        m_ptr  = NREQ - 1;
        m_val  = '0;
        m_rerr = 1'b0;
        for (int k = 0; k < NREQ; k++) m_bcd[k] = 8'h00;
    endtask

    task automatic model_step();
        if (m_cyc == 0) begin
            if (req != '0) begin
                for (int i = 1; i <= NREQ; i++) begin
                    if (req[(m_ptr + i) % NREQ]) begin
                        m_k = (m_ptr + i) % NREQ;
                        break;
                    end
                end
                m_val = bin_in[6*m_k +: 6];
                m_cyc = 1;
            end
        end else begin
            m_cyc++;
            if (m_cyc == CONV_LAT + 2) begin
                m_bcd[m_k] = {4'(m_val / 10), 4'(m_val % 10)};
                m_rerr     = (m_val > 59) || (conv_hundred != 4'd0);
                m_ptr      = m_k;
            end
            if (m_cyc == CONV_LAT + 3) m_cyc = 0;
        end
    endtask

    initial begin
        logic [NREQ-1:0]   e_grant;
        logic [NREQ-1:0]   e_ack;
        logic [8*NREQ-1:0] e_bcd;
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
            #1;
            e_grant = (m_cyc >= 1 && m_cyc <= CONV_LAT + 1) ? NREQ'(1) << m_k : '0;
            e_ack   = (m_cyc == CONV_LAT + 2) ? NREQ'(1) << m_k : '0;
            for (int k = 0; k < NREQ; k++) e_bcd[8*k +: 8] = m_bcd[k];
            check("cyc_grant", 32'(grant), 32'(e_grant));
            check("cyc_ack", 32'(ack), 32'(e_ack));
            check("cyc_bcd_out", 32'(bcd_out), 32'(e_bcd));
            check("cyc_conv_bin", 32'(conv_bin), 32'(m_val));
            check("cyc_busy", 32'(busy), 32'(m_cyc != 0));
            check("cyc_range_err", 32'(range_err), 32'((m_cyc == CONV_LAT + 2) && m_rerr));
        end
    end

    task automatic wait_ack(output logic [NREQ-1:0] a, output int cycles);
        cycles = 0;
        a      = '0;
        while (cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (ack != '0) begin
                a = ack;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL ack_timeout: got no ack expected one within 50 cycles");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] a;
        int              c;
        logic [NREQ-1:0] seq [4];
        seq = '{3'b001, 3'b010, 3'b100, 3'b001};

        reset_n = 1'b0;
        req     = '0;
        bin_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_conv_bin", 32'(conv_bin), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_bcd_out", 32'(bcd_out), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Single conversion of 45 by requester 0.
        @(negedge clk);
        bin_in[5:0] = 6'd45;
        req         = 3'b001;
        @(negedge clk);
        check("t1_conv_bin", 32'(conv_bin), 32'd45);
        check("t1_grant", 32'(grant), 32'b001);
        wait_ack(a, c);
        check("t1_ack", 32'(a), 32'b001);
        check("t1_latency", 32'(c), 32'd2);
        check("t1_bcd0", 32'(bcd_out[7:0]), 32'h45);
        check("t1_range_err", 32'(range_err), 32'd0);
        req = '0;

        // All three requesting: strict rotation at CONV_LAT+3 spacing.
        do_reset();
        bin_in = {6'd56, 6'd34, 6'd12};
        req    = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, c);
            check("t2_rr_order", 32'(a), 32'(seq[i]));
            if (i > 0) check("t2_rr_spacing", 32'(c), 32'd4);
        end
        check("t2_bcd_all", 32'(bcd_out), 32'h563412);

        // Requester 0 just served, 0 and 1 pending: 1 must go first.
        req = 3'b011;
        wait_ack(a, c);
        check("t3_first", 32'(a), 32'b010);
        req = 3'b001;
        wait_ack(a, c);
        check("t3_second", 32'(a), 32'b001);
        req = '0;

        // Snapshot: bin changes one cycle after the grant do not leak in.
        repeat (2) @(negedge clk);
        bin_in[5:0] = 6'd59;
        req         = 3'b001;
        @(negedge clk);
        check("t4_grant", 32'(grant), 32'b001);
        @(negedge clk);
        bin_in[5:0] = 6'd7;
        wait_ack(a, c);
        check("t4_bcd_59", 32'(bcd_out[7:0]), 32'h59);
        req = '0;
        repeat (2) @(negedge clk);
        req = 3'b001;
        wait_ack(a, c);
        check("t4_bcd_07", 32'(bcd_out[7:0]), 32'h07);
        req = '0;

        // Out-of-range values and a nonzero hundreds digit.
        repeat (2) @(negedge clk);
        bin_in[17:12] = 6'd62;
        req           = 3'b100;
        wait_ack(a, c);
        check("t5_ack", 32'(a), 32'b100);
        check("t5_bcd2", 32'(bcd_out[23:16]), 32'h62);
        check("t5_range_err", 32'(range_err), 32'd1);
        req = '0;
        @(negedge clk);
        check("t5_rerr_pulse", 32'(range_err), 32'd0);
        bin_in[5:0] = 6'd10;
        hund_force  = 1'b1;
        req         = 3'b001;
        wait_ack(a, c);
        check("t5_hund_rerr", 32'(range_err), 32'd1);
        check("t5_hund_bcd", 32'(bcd_out[7:0]), 32'h10);
        req        = '0;
        @(negedge clk);
        hund_force = 1'b0;

        // Reset during WAIT clears everything and restarts the rotation.
        bin_in[5:0] = 6'd20;
        req         = 3'b001;
        wait_ack(a, c);
        req = '0;
        repeat (2) @(negedge clk);
        bin_in = {6'd33, 6'd21, 6'd20};
        req    = 3'b011;
        @(negedge clk);
        check("t6_grant_pre", 32'(grant), 32'b010);
        reset_n = 1'b0;
        #1;
        check("t6_grant_rst", 32'(grant), 32'd0);
        check("t6_ack_rst", 32'(ack), 32'd0);
        check("t6_bcd_rst", 32'(bcd_out), 32'd0);
        check("t6_busy_rst", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ack(a, c);
        check("t6_restart0", 32'(a), 32'b001);
        check("t6_bcd0", 32'(bcd_out[7:0]), 32'h20);
        req = 3'b010;
        wait_ack(a, c);
        check("t6_then1", 32'(a), 32'b010);
        check("t6_bcd1", 32'(bcd_out[15:8]), 32'h21);
        req = '0;

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares one Binary_to_BCD converter (6-bit binary in; hundred/tens/ones out) among NREQ requesters, e.g. the hours, minutes and seconds counters of the clock/stopwatch.
- Round-robin arbiter plus sequencer: snapshots the granted binary value, drives the converter, waits the converter latency, then captures tens/ones into a per-requester BCD register and pulses that requester's ack.
- Sits between the time-keeping counters and the 7-segment display mux.

Parameters:
- NREQ, 3, number of requesters (2..4 supported).
- CONV_LAT, 1, cycles from a conv_bin change to valid converter outputs (registered converter = 1; combinational = 0).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req  in  NREQ  level request per requester; held until its ack.
- bin_in  in  6*NREQ  binary values, requester k at bits [6k+5:6k].
- conv_bin  out  6  registered operand to the shared converter.
- conv_hundred  in  4  converter hundreds digit; checked only.
- conv_tens  in  4  converter tens digit.
- conv_ones  in  4  converter ones digit.
- grant  out  NREQ  one-hot, registered; high from grant until ack.
- ack  out  NREQ  one-cycle pulse, one-hot; the BCD result for that requester is valid.
- bcd_out  out  8*NREQ  per-requester {tens,ones}, held until overwritten.
- range_err  out  1  one-cycle pulse with ack; the converted value was >59.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; conv_bin=0; grant=0; ack=0; bcd_out=all 0; range_err=0; busy=0; RR pointer=NREQ-1, so requester 0 has first priority.
- FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - When any req bit is high at edge E0, select the first requester searching upward from pointer+1 with wrap.
  - At E0: grant[k]<=1, conv_bin<=bin_in[k] (snapshot), wait counter<=CONV_LAT, state<=WAIT.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0: sample conv_tens/conv_ones into bcd_out[k]; ack[k]<=1; range_err<=(conv_bin>59); grant<=0; pointer<=k; state<=DONE.
  - Capture occurs at edge E0+CONV_LAT+1.
- DONE: ack high exactly this cycle. Next edge: ack<=0, range_err<=0, state<=IDLE.
- No arbitration in DONE. Throughput is one conversion per CONV_LAT+3 cycles.
- Snapshot rule: bin_in changes after E0 do not affect the current conversion.
- req dropped mid-conversion: the conversion still completes, and bcd_out and ack are updated.
- req still high after ack: the requester is re-eligible, but all other pending requesters are served first (fairness bound of NREQ-1 waits).
- Simultaneous requests: resolved only by the round-robin order, never by fixed priority.
- conv_hundred: ignored for data, because a 6-bit input never exceeds 63. A nonzero value at capture also asserts range_err.
- Values 60..63 are still converted and stored (e.g. 63 -> 0x63) with range_err.
- Reset mid-operation: immediately returns to the reset values. No ack is issued and bcd_out is cleared.
- Only one grant and one ack bit may be high at any time.

Test Plan:
- Reset, then req=001, bin0=45, CONV_LAT=1 -> conv_bin=45 after E0; capture at E0+2; ack=001 during the next cycle; bcd_out[7:0]=0x45; range_err=0.
- req=111 held, bin=(12,34,56) -> acks in order 001,010,100,001,... at 4-cycle spacing; bcd_out={0x56,0x34,0x12}.
- req=011 asserted in the same cycle just after requester 0 was served -> requester 1 is granted first.
- bin0=59 granted, bin0 changed to 7 one cycle later -> bcd_out[7:0]=0x59; the 7 is converted only on the next request.
- bin2=62 -> bcd_out[23:16]=0x62; range_err pulses with ack=100. Forcing conv_hundred=1 with bin=10 -> range_err=1.
- reset_n pulsed low during WAIT -> grant, ack and bcd_out are 0 immediately; after release, a pending req restarts from requester 0.
